// File: rtl/aes_ct_serializer.sv
// -----------------------------------------------------------------------------
// aes_ct_serializer
//
// Purpose:
//   Sits behind the AES encryptor. Each completed 128-bit ciphertext arrives
//   with a one-cycle strobe and is captured into a small block FIFO. The head
//   block is then streamed out one byte per transfer, MSB byte first, over a
//   byte-wide valid/ready interface. This lets a fixed-latency encryptor feed
//   a consumer that applies back-pressure (UART/SPI transmitter, host bus).
//
// Parameters:
//   ADDR_W       log2 of the FIFO depth in 128-bit blocks (DEPTH = 2**ADDR_W).
//                Must be at least 1.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous, active-high reset
//   ct_in        ciphertext block; bits [127:120] are transmitted first
//   ct_valid     one-cycle strobe qualifying ct_in
//   out_data     current output byte (registered)
//   out_valid    out_data holds a valid byte
//   out_ready    consumer accepts the byte (transfer = out_valid && out_ready)
//   out_last     asserted with the 16th byte of a block
//   overflow     sticky; set when a ct_valid strobe had to be dropped
//   blocks_sent  number of fully transmitted blocks, wraps modulo 2**16
// -----------------------------------------------------------------------------
module aes_ct_serializer #(
    parameter int ADDR_W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] ct_in,
    input  logic         ct_valid,
    output logic [7:0]   out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         overflow,
    output logic [15:0]  blocks_sent
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [3:0]        LAST_IDX = 4'd15;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t            state;

    // Block storage and FIFO bookkeeping
    logic [127:0]      mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;

    // Byte position within the head block (0 = bits [127:120])
    logic [3:0]        idx;

    // Next-cycle values, computed combinationally and registered below
    logic              xfer;
    logic              pop;
    logic              push;
    logic [ADDR_W:0]   count_after_pop;
    logic [ADDR_W:0]   count_nxt;
    logic [ADDR_W-1:0] rd_ptr_nxt;
    logic              head_is_new;
    logic [127:0]      head_nxt;
    logic              send_nxt;
    logic [3:0]        idx_nxt;
    logic [7:0]        out_data_nxt;

    // Byte i of a block, byte 0 being the most significant. The bit offset of
    // byte i is 8*(15-i), which for a 4-bit i is simply {~i, 3'b000}.
    function automatic logic [7:0] byte_sel(input logic [127:0] blk,
                                            input logic [3:0]   i);
        logic [6:0] lsb;
        lsb = {~i, 3'b000};
        return blk[lsb +: 8];
    endfunction

    always_comb begin
        xfer = (state == SEND) && out_ready;

        // The head block is retired on the transfer of its last byte.
        pop = xfer && (idx == LAST_IDX);

        // A full FIFO can still accept a block if a slot frees this cycle.
        push = ct_valid && ((count != FULL_CNT) || pop);

        count_after_pop = pop ? (count - CNT_ONE) : count;
        count_nxt       = push ? (count_after_pop + CNT_ONE) : count_after_pop;

        rd_ptr_nxt = pop ? (rd_ptr + PTR_ONE) : rd_ptr;

        // If the incoming block becomes the head right away (FIFO empty once
        // any pop is accounted for), it is not in the array yet; bypass it so
        // byte 0 appears one cycle after the strobe.
        head_is_new = push && (count_after_pop == '0);
        head_nxt    = head_is_new ? ct_in : mem[rd_ptr_nxt];

        // Whenever anything is buffered we are (or stay) in SEND; this also
        // gives bubble-free back-to-back blocks after a pop.
        send_nxt = (count_nxt != '0);

        // idx wraps 15 -> 0 naturally on the pop transfer.
        if (!send_nxt) begin
            idx_nxt = 4'd0;
        end else if (xfer) begin
            idx_nxt = idx + 4'd1;
        end else begin
            idx_nxt = idx;
        end

        out_data_nxt = send_nxt ? byte_sel(head_nxt, idx_nxt) : 8'd0;
    end

    // FSM, FIFO control and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            idx         <= 4'd0;
            out_data    <= 8'd0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            overflow    <= 1'b0;
            blocks_sent <= 16'd0;
        end else begin
            case (state)
                IDLE: state <= send_nxt ? SEND : IDLE;
                SEND: state <= send_nxt ? SEND : IDLE;
                default: state <= IDLE;
            endcase

            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
            idx    <= idx_nxt;

            out_data  <= out_data_nxt;
            out_valid <= send_nxt;
            out_last  <= send_nxt && (idx_nxt == LAST_IDX);

            if (pop) begin
                blocks_sent <= blocks_sent + 16'd1;
            end

            // A strobe that could not be stored is lost; remember that.
            if (ct_valid && !push) begin
                overflow <= 1'b1;
            end
        end
    end

    // Block storage is data only and needs no reset; writes are suppressed
    // during reset so a strobe in that cycle leaves no trace.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= ct_in;
        end
    end

endmodule

// File: tb/tb_aes_ct_serializer.sv
module tb_aes_ct_serializer;

    localparam int ADDR_W = 1;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] ct_in;
    logic         ct_valid;
    logic [7:0]   out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic         overflow;
    logic [15:0]  blocks_sent;

    always #5 clk = ~clk;

    aes_ct_serializer #(.ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .ct_in       (ct_in),
        .ct_valid    (ct_valid),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .overflow    (overflow),
        .blocks_sent (blocks_sent)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // mq : blocks held by the serializer (head first)
    // eq : scoreboard of expected bytes {last, data}, pushed when a block is accepted
    logic [127:0] mq[$];
    logic [8:0]   eq[$];
    int           m_idx  = 0;
    logic         m_ovf  = 1'b0;
    logic [15:0]  m_sent = 16'd0;
    bit           started = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            eq.delete();
            m_idx  = 0;
            m_ovf  = 1'b0;
            m_sent = 16'd0;
        end else begin
            // Output is valid exactly when a block is held.
            if (mq.size() > 0 && out_ready) begin
                m_idx++;
                if (m_idx == 16) begin
                    void'(mq.pop_front());
                    m_idx  = 0;
                    m_sent = m_sent + 16'd1;
                end
            end
            if (ct_valid) begin
                if (mq.size() < DEPTH) begin
                    logic [127:0] blk;
                    blk = ct_in;
                    mq.push_back(blk);
                    for (int b = 0; b < 16; b++) begin
                        logic [127:0] sh;
                        sh = blk >> (8 * (15 - b));
                        eq.push_back({(b == 15), sh[7:0]});
                    end
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'd0;
    logic       prev_last  = 1'b0;

    always @(negedge clk) begin
        if (started) begin
            check("out_valid", 32'(out_valid), 32'(mq.size() > 0));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("blocks_sent", 32'(blocks_sent), 32'(m_sent));
            if (prev_stall) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", 32'(out_data), 32'(prev_data));
                check("stall_last", 32'(out_last), 32'(prev_last));
            end
            if (out_valid && out_ready && !rst) begin
                if (eq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_byte: got %02h expected no byte", out_data);
                end else begin
                    logic [8:0] e;
                    e = eq.pop_front();
                    check("out_data", 32'(out_data), 32'(e[7:0]));
                    check("out_last", 32'(out_last), 32'(e[8]));
                end
            end
            prev_stall = out_valid && !out_ready && !rst;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ct_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic push_block(input logic [127:0] blk);
        ct_in    = blk;
        ct_valid = 1'b1;
        tick();
        ct_valid = 1'b0;
        ct_in    = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    // mode 0: ready always; 1: ready pattern 1,0,0,...; 2: random ready
    task automatic drain(input string name, input int mode, input int budget);
        int k;
        k = 0;
        while ((mq.size() != 0 || eq.size() != 0) && k < budget) begin
            case (mode)
                1:       out_ready = (k % 3 == 0);
                2:       out_ready = ($urandom_range(0, 1) == 1);
                default: out_ready = 1'b1;
            endcase
            tick();
            k++;
        end
        check({name, "_drained"}, 32'(mq.size() + eq.size()), 32'd0);
        out_ready = 1'b1;
    endtask

    task automatic check_idle(input string name);
        check({name, "_valid"}, 32'(out_valid), 32'd0);
        check({name, "_data"}, 32'(out_data), 32'd0);
        check({name, "_last"}, 32'(out_last), 32'd0);
        check({name, "_overflow"}, 32'(overflow), 32'd0);
        check({name, "_sent"}, 32'(blocks_sent), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] a;
        logic [127:0] b;
        rst       = 1'b1;
        ct_valid  = 1'b0;
        ct_in     = '0;
        out_ready = 1'b0;
        tick();
        tick();
        started = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        check_idle("reset");

        // Single block, consumer always ready
        tick();
        out_ready = 1'b1;
        push_block(128'h3925841d02dc09fbdc118597196a0b32);
        drain("single", 0, 100);
        @(negedge clk);
        check("single_sent", 32'(blocks_sent), 32'd1);
        check("single_idle", 32'(out_valid), 32'd0);

        // Same block under back-pressure
        tick();
        do_reset();
        out_ready = 1'b1;
        push_block(128'h3925841d02dc09fbdc118597196a0b32);
        drain("bp", 1, 200);
        @(negedge clk);
        check("bp_sent", 32'(blocks_sent), 32'd1);

        // Back-to-back blocks two cycles apart
        tick();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            a[127 - 8 * i -: 8] = 8'(i);
            b[127 - 8 * i -: 8] = 8'(8'hF0 + i);
        end
        out_ready = 1'b1;
        push_block(a);
        tick();
        push_block(b);
        drain("b2b", 0, 100);
        @(negedge clk);
        check("b2b_sent", 32'(blocks_sent), 32'd2);

        // Overflow: three strobes into a two-deep FIFO with the consumer stalled
        tick();
        do_reset();
        out_ready = 1'b0;
        push_block({$urandom(), $urandom(), $urandom(), $urandom()});
        push_block({$urandom(), $urandom(), $urandom(), $urandom()});
        push_block({$urandom(), $urandom(), $urandom(), $urandom()});
        @(negedge clk);
        check("ovf_flag", 32'(overflow), 32'd1);
        tick();
        drain("ovf", 0, 100);
        @(negedge clk);
        check("ovf_sent", 32'(blocks_sent), 32'd2);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Full FIFO with a push coinciding with the last-byte transfer
        tick();
        do_reset();
        out_ready = 1'b0;
        push_block({$urandom(), $urandom(), $urandom(), $urandom()});
        push_block({$urandom(), $urandom(), $urandom(), $urandom()});
        out_ready = 1'b1;
        repeat (15) tick();
        push_block(128'hCAFEBABE_DEADBEEF_01234567_89ABCDEF);
        @(negedge clk);
        check("fullpop_ovf", 32'(overflow), 32'd0);
        tick();
        drain("fullpop", 0, 100);
        @(negedge clk);
        check("fullpop_sent", 32'(blocks_sent), 32'd3);

        // Reset in the middle of a block with a second block buffered
        tick();
        do_reset();
        out_ready = 1'b1;
        push_block({$urandom(), $urandom(), $urandom(), $urandom()});
        push_block({$urandom(), $urandom(), $urandom(), $urandom()});
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_idle("midrst");
        tick();
        push_block(128'h00112233_44556677_8899AABB_CCDDEEFF);
        drain("midrst", 0, 100);
        @(negedge clk);
        check("midrst_sent", 32'(blocks_sent), 32'd1);

        // Randomised traffic with random back-pressure and rare resets
        tick();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            ct_valid  = ($urandom_range(0, 9) == 0);
            ct_in     = {$urandom(), $urandom(), $urandom(), $urandom()};
            out_ready = ($urandom_range(0, 9) < 7);
            rst       = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst      = 1'b0;
        ct_valid = 1'b0;
        drain("random", 0, 200);
        @(negedge clk);
        check("random_idle", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
